// File: rtl/adc_fifo_pkg.sv
// Shared constants for the ADC sample FIFO: register offsets,
// CTRL/STATUS bit positions and the DATA word field layout.
package adc_fifo_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_THRESH = 2'd3;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    localparam int ST_LEVEL_W   = 11;
    localparam int ST_EMPTY_BIT = 16;
    localparam int ST_FULL_BIT  = 17;
    localparam int ST_OVF_BIT   = 18;

    localparam int THRESH_W = 11;

    // DATA word: valid flag on top, channel directly above the sample,
    // zero padding in between.
    localparam int DATA_VALID_BIT = 31;
    localparam int CHAN_W         = 3;

endpackage

// File: rtl/adc_sample_fifo_ram.sv
// sync_fifo_ram: simple dual-port storage with registered read (M10K).
// Ports: clk, we/waddr/wdata write port, raddr read port, rdata one cycle later.
module sync_fifo_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 19
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/adc_sample_fifo.sv
// ADC sample FIFO with an Avalon-MM register slave for the HPS.
// Ports: clk_clk/reset_reset, sample_* push side, avs_* slave, irq level out.
module adc_sample_fifo
    import adc_fifo_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic [2:0]          sample_chan,
    input  logic [1:0]          avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    output logic                avs_readdatavalid,
    output logic                irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = SAMPLE_W + CHAN_W;

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                enable_q, enable_d;
    logic                ovf_q, ovf_d;
    logic [THRESH_W-1:0] thresh_q, thresh_d;
    logic                irq_q, irq_d;
    logic                rdv_q, rdv_d;
    logic                data_sel_q, data_sel_d;
    logic [31:0]         readdata_q, readdata_d;

    logic             empty, full, push, pop, flush;
    logic [31:0]      status_word, data_word;
    logic [ENT_W-1:0] ram_rdata;
    logic             unused_wdata;

    assign unused_wdata = ^avs_writedata;

    sync_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_ram (
        .clk   (clk_clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata ({sample_chan, sample_data}),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        empty = (level_q == '0);
        full  = (level_q == LVL_W'(DEPTH));
        flush = avs_write && (avs_address == REG_CTRL)
                && avs_writedata[CTRL_FLUSH_BIT];
        pop   = avs_read && (avs_address == REG_DATA) && !empty;
        // A flush discards a same-cycle sample.
        push  = sample_valid && enable_q && !full && !flush;

        status_word = '0;
        status_word[LVL_W-1:0]    = level_q;
        status_word[ST_EMPTY_BIT] = empty;
        status_word[ST_FULL_BIT]  = full;
        status_word[ST_OVF_BIT]   = ovf_q;

        data_word = '0;
        data_word[DATA_VALID_BIT]            = 1'b1;
        data_word[SAMPLE_W +: CHAN_W]        = ram_rdata[SAMPLE_W +: CHAN_W];
        data_word[SAMPLE_W-1:0]              = ram_rdata[SAMPLE_W-1:0];
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        enable_d   = enable_q;
        thresh_d   = thresh_q;
        ovf_d      = ovf_q;
        rdv_d      = avs_read;
        data_sel_d = 1'b0;
        readdata_d = '0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        end

        if (avs_write) begin
            unique case (avs_address)
                REG_CTRL:   enable_d = avs_writedata[CTRL_EN_BIT];
                REG_THRESH: thresh_d = avs_writedata[THRESH_W-1:0];
                default:    ;
            endcase
        end

        // Set wins over a same-cycle write-1-to-clear.
        if (avs_write && (avs_address == REG_STATUS)
            && avs_writedata[ST_OVF_BIT]) begin
            ovf_d = 1'b0;
        end
        if (sample_valid && enable_q && full) begin
            ovf_d = 1'b1;
        end

        // Register reads capture pre-write values; DATA comes from the RAM.
        if (avs_read) begin
            unique case (avs_address)
                REG_CTRL:   readdata_d = 32'(enable_q);
                REG_STATUS: readdata_d = status_word;
                REG_DATA:   data_sel_d = !empty;
                REG_THRESH: readdata_d = 32'(thresh_q);
                default:    ;
            endcase
        end

        irq_d = ((thresh_q != '0) && (32'(level_q) >= 32'(thresh_q)))
                || ovf_q;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            enable_q   <= 1'b0;
            ovf_q      <= 1'b0;
            thresh_q   <= '0;
            irq_q      <= 1'b0;
            rdv_q      <= 1'b0;
            data_sel_q <= 1'b0;
            readdata_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            enable_q   <= enable_d;
            ovf_q      <= ovf_d;
            thresh_q   <= thresh_d;
            irq_q      <= irq_d;
            rdv_q      <= rdv_d;
            data_sel_q <= data_sel_d;
            readdata_q <= readdata_d;
        end
    end

    // Masking with reset kills a pending valid pulse as soon as reset rises.
    assign avs_readdatavalid = rdv_q && !reset_reset;
    assign avs_readdata      = reset_reset ? '0
                             : (data_sel_q ? data_word : readdata_q);
    assign irq               = irq_q;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Self-checking bench for adc_sample_fifo (DEPTH=16) with a data scoreboard.
// Ports: none; drives the DUT and prints one summary line.
module tb_adc_sample_fifo;

    localparam int DEPTH = 16;
    localparam int SW    = 16;

    logic          clk_clk = 1'b0;
    logic          reset_reset;
    logic          sample_valid;
    logic [SW-1:0] sample_data;
    logic [2:0]    sample_chan;
    logic [1:0]    avs_address;
    logic          avs_read;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic [31:0]   avs_readdata;
    logic          avs_readdatavalid;
    logic          irq;

    adc_sample_fifo #(
        .DEPTH    (DEPTH),
        .SAMPLE_W (SW)
    ) dut (
        .clk_clk           (clk_clk),
        .reset_reset       (reset_reset),
        .sample_valid      (sample_valid),
        .sample_data       (sample_data),
        .sample_chan       (sample_chan),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .irq               (irq)
    );

    always #5 clk_clk = ~clk_clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] sb[$];
    int          m_lvl;
    logic        m_en;
    logic        m_ovf;
    logic [31:0] rd;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    function automatic logic [31:0] fmt(input logic [2:0] c,
                                        input logic [SW-1:0] s);
        return 32'h8000_0000 | (32'(c) << 16) | 32'(s);
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] w;
        w = 32'(m_lvl);
        w[16] = (m_lvl == 0);
        w[17] = (m_lvl == DEPTH);
        w[18] = m_ovf;
        return w;
    endfunction

    task automatic model_push(input logic [2:0] c, input logic [SW-1:0] s);
        if (m_en) begin
            if (m_lvl < DEPTH) begin
                sb.push_back(fmt(c, s));
                m_lvl++;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic push_sample(input logic [2:0] c, input logic [SW-1:0] s);
        sample_valid = 1'b1;
        sample_chan  = c;
        sample_data  = s;
        tick();
        sample_valid = 1'b0;
        model_push(c, s);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        avs_write     = 1'b1;
        avs_address   = a;
        avs_writedata = d;
        tick();
        avs_write = 1'b0;
        if (a == 2'd0) begin
            m_en = d[0];
            if (d[1]) begin
                m_lvl = 0;
                sb.delete();
            end
        end
        if (a == 2'd1 && d[18]) m_ovf = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] d);
        avs_read    = 1'b1;
        avs_address = a;
        tick();
        avs_read = 1'b0;
        check("rdv", 32'(avs_readdatavalid), 32'd1);
        d = avs_readdata;
    endtask

    task automatic read_data_chk(input string tag);
        logic [31:0] e;
        logic [31:0] d;
        e = 32'h0;
        if (m_lvl > 0) begin
            e = sb.pop_front();
            m_lvl--;
        end
        do_read(2'd2, d);
        check(tag, d, e);
    endtask

    task automatic status_chk(input string tag);
        logic [31:0] d;
        do_read(2'd1, d);
        check(tag, d, exp_status());
    endtask

    initial begin
        reset_reset   = 1'b1;
        sample_valid  = 1'b0;
        sample_data   = '0;
        sample_chan   = '0;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        m_lvl = 0;
        m_en  = 1'b0;
        m_ovf = 1'b0;
        repeat (3) tick();
        check("rst_rdv", 32'(avs_readdatavalid), 32'd0);
        check("rst_rdata", avs_readdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        reset_reset = 1'b0;
        tick();
        status_chk("rst_status");
        do_read(2'd0, rd);
        check("rst_ctrl", rd, 32'd0);
        do_read(2'd3, rd);
        check("rst_thresh", rd, 32'd0);

        // Disabled samples are ignored without overflow.
        push_sample(3'd1, 16'hdead);
        status_chk("dis_status");

        // Basic flow with fixed expected words.
        do_write(2'd0, 32'd1);
        push_sample(3'd2, 16'h1234);
        push_sample(3'd2, 16'h5678);
        push_sample(3'd2, 16'h9abc);
        check("sb_word0", sb[0], 32'h8002_1234);
        read_data_chk("basic0");
        read_data_chk("basic1");
        read_data_chk("basic2");
        do_read(2'd1, rd);
        check("basic_status", rd, 32'h0001_0000);
        read_data_chk("empty_read");
        status_chk("empty_nopop");

        // Overflow: 20 pushes into 16 entries.
        for (int i = 0; i < 20; i++)
            push_sample(3'(i), 16'(16'h0100 + i));
        do_read(2'd1, rd);
        check("ovf_status", rd, 32'h0006_0010);
        tick();
        check("ovf_irq", 32'(irq), 32'd1);
        read_data_chk("ovf_first");
        do_write(2'd1, 32'h0004_0000);
        status_chk("w1c_status");
        tick();
        check("w1c_irq", 32'(irq), 32'd0);

        // Drain to 8, then flush with a simultaneous sample.
        while (m_lvl > 8) read_data_chk("drain8");
        status_chk("lvl8");
        avs_write     = 1'b1;
        avs_address   = 2'd0;
        avs_writedata = 32'd3;
        sample_valid  = 1'b1;
        sample_data   = 16'h7777;
        tick();
        avs_write    = 1'b0;
        sample_valid = 1'b0;
        m_en  = 1'b1;
        m_lvl = 0;
        sb.delete();
        status_chk("flush_status");
        do_read(2'd0, rd);
        check("flush_en", rd, 32'd1);

        // Concurrent push and pop at level 5.
        for (int i = 0; i < 5; i++) push_sample(3'd5, 16'(16'h5000 + i));
        for (int i = 0; i < 10; i++) begin
            logic [31:0] e;
            e = sb.pop_front();
            sample_valid = 1'b1;
            sample_chan  = 3'd6;
            sample_data  = 16'(16'h6000 + i);
            avs_read     = 1'b1;
            avs_address  = 2'd2;
            tick();
            sample_valid = 1'b0;
            avs_read     = 1'b0;
            sb.push_back(fmt(3'd6, 16'(16'h6000 + i)));
            check("pp_rdv", 32'(avs_readdatavalid), 32'd1);
            check("pp_data", avs_readdata, e);
        end
        status_chk("pp_level");
        while (m_lvl > 0) read_data_chk("pp_drain");

        // Read/write THRESH together returns the old value.
        do_write(2'd3, 32'd9);
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        avs_address   = 2'd3;
        avs_writedata = 32'd4;
        tick();
        avs_read  = 1'b0;
        avs_write = 1'b0;
        check("rw_old", avs_readdata, 32'd9);
        do_read(2'd3, rd);
        check("rw_new", rd, 32'd4);

        // Threshold interrupt with one-cycle lag.
        for (int i = 0; i < 3; i++) push_sample(3'd3, 16'(16'h3000 + i));
        tick();
        check("thr_irq3", 32'(irq), 32'd0);
        push_sample(3'd3, 16'h3003);
        check("thr_lag", 32'(irq), 32'd0);
        tick();
        check("thr_irq4", 32'(irq), 32'd1);
        read_data_chk("thr_pop");
        tick();
        check("thr_irq_drop", 32'(irq), 32'd0);
        while (m_lvl > 0) read_data_chk("thr_drain");
        do_write(2'd3, 32'd0);

        // Pointer wrap over 3*DEPTH entries.
        for (int i = 0; i < 2; i++) push_sample(3'd7, 16'(16'ha000 + i));
        for (int i = 0; i < 3 * DEPTH; i++) begin
            push_sample(3'(i), 16'($urandom_range(0, 65535)));
            read_data_chk("wrap");
        end
        while (m_lvl > 0) read_data_chk("wrap_drain");
        status_chk("wrap_status");

        // Reset right after a read kills the valid pulse.
        for (int i = 0; i < DEPTH + 1; i++) push_sample(3'd1, 16'(i));
        avs_read    = 1'b1;
        avs_address = 2'd1;
        tick();
        avs_read    = 1'b0;
        reset_reset = 1'b1;
        #1;
        check("rst_kill_rdv", 32'(avs_readdatavalid), 32'd0);
        tick();
        check("rst_after_rdv", 32'(avs_readdatavalid), 32'd0);
        reset_reset = 1'b0;
        m_lvl = 0;
        m_en  = 1'b0;
        m_ovf = 1'b0;
        sb.delete();
        tick();
        check("rst2_irq", 32'(irq), 32'd0);
        do_read(2'd1, rd);
        check("rst2_status", rd, 32'h0001_0000);
        do_read(2'd0, rd);
        check("rst2_ctrl", rd, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
